// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped I/O block on the data-memory bus.
// Decodes 0xFFF0-0xFFFC, owns the HEX/LEDR/LEDG registers, debounces KEY/SW,
// latches key-press events and runs a free-running millisecond timer.
module io_bus_ctrl #(
  parameter int unsigned DBITS       = 16,
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned TICK_CYCLES = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ADDR,
  input  logic [DBITS-1:0] DIN,
  input  logic             WE,
  output logic [DBITS-1:0] DOUT,
  output logic             SEL,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [DBITS-1:0] HEX,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  // Word index within the I/O page (ADDR[3:1]); index 7 (0xFFFE) is unmapped.
  typedef enum logic [2:0] {
    R_KDATA = 3'd0,
    R_SDATA = 3'd1,
    R_KEVT  = 3'd2,
    R_TIMER = 3'd3,
    R_HEX   = 3'd4,
    R_LEDR  = 3'd5,
    R_LEDG  = 3'd6,
    R_NONE  = 3'd7
  } reg_sel_e;

  logic             io_hit;
  reg_sel_e         rsel;
  logic             wr;
  logic             unused_addr_lsb;

  logic [3:0]       key_s1, key_s2;
  logic [9:0]       sw_s1, sw_s2;
  logic [13:0]      syn;      // {SW, KEY} after the synchronizer
  logic [13:0]      stab;     // {SW, KEY} debounced; KEY part is raw active-low
  logic [13:0]      accept;
  logic [DW-1:0]    deb_cnt [14];

  logic [3:0]       kdata;
  logic [3:0]       press;
  logic [3:0]       kevt;
  logic [3:0]       kevt_clr;
  logic [TW-1:0]    presc;
  logic [DBITS-1:0] timer;

  assign io_hit          = &ADDR[DBITS-1:4];
  assign rsel            = reg_sel_e'(ADDR[3:1]);
  assign SEL             = io_hit && (rsel != R_NONE);
  assign wr              = WE && SEL;
  assign unused_addr_lsb = ADDR[0];

  assign syn      = {sw_s2, key_s2};
  assign kdata    = ~stab[3:0];
  assign press    = accept[3:0] & stab[3:0];
  assign kevt_clr = (wr && rsel == R_KEVT) ? DIN[3:0] : 4'h0;

  // Two-flop synchronizers for the asynchronous KEY and SW pins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

  // A bit is accepted on its DEB_CYCLES-th consecutive cycle differing from stable.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      accept[i] = (syn[i] != stab[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  // Per-bit debounce counters and stable levels.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stab <= {10'b0, 4'hF};
      for (int unsigned i = 0; i < 14; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      stab <= stab ^ accept;
      for (int unsigned i = 0; i < 14; i++) begin
        if ((syn[i] == stab[i]) || accept[i]) begin
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Sticky press events; a same-cycle press overrides the write-1-to-clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      kevt <= '0;
    end else begin
      kevt <= (kevt & ~kevt_clr) | press;
    end
  end

  // Millisecond timer; a bus write loads it and restarts the prescaler.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc <= '0;
      timer <= '0;
    end else if (wr && rsel == R_TIMER) begin
      presc <= '0;
      timer <= DIN;
    end else if (presc == TICK_LAST) begin
      presc <= '0;
      timer <= timer + DBITS'(1);
    end else begin
      presc <= presc + TW'(1);
    end
  end

  // Output registers written from the store path.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HEX  <= '0;
      LEDR <= '0;
      LEDG <= '0;
    end else if (wr) begin
      if (rsel == R_HEX)  HEX  <= DIN;
      if (rsel == R_LEDR) LEDR <= DIN[9:0];
      if (rsel == R_LEDG) LEDG <= DIN[7:0];
    end
  end

  // Combinational read mux; unmapped addresses return 0xDEAD.
  always_comb begin
    DOUT = DBITS'(16'hDEAD);
    if (io_hit) begin
      case (rsel)
        R_KDATA: DOUT = DBITS'(kdata);
        R_SDATA: DOUT = DBITS'(stab[13:4]);
        R_KEVT:  DOUT = DBITS'(kevt);
        R_TIMER: DOUT = timer;
        R_HEX:   DOUT = HEX;
        R_LEDR:  DOUT = DBITS'(LEDR);
        R_LEDG:  DOUT = DBITS'(LEDG);
        default: DOUT = DBITS'(16'hDEAD);
      endcase
    end
  end

endmodule
